// File: rtl/packet_egress_if.sv
// Egress word stream of the packet buffer: 64-bit words on a valid/ready
// handshake, with start/end-of-packet markers.
interface packet_egress_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop,
    output out_ready
  );
endinterface

// File: rtl/packet_egress_buffer.sv
// Two-entry egress queue for decoded 1568-bit packets: drops CRC failures and
// overflows (saturating counters), streams each kept packet as 25 x 64-bit words.
module packet_egress_buffer #(
  parameter int CNT_W = 16
) (
  input  logic              clk_390p625M,
  input  logic              rst,
  input  logic              pkt_strobe,
  input  logic [1567:0]     data_1568bit,
  input  logic              crc10_check_result,
  packet_egress_if.master   out_if,
  output logic [1:0]        buf_level,
  output logic [CNT_W-1:0]  drop_crc_cnt,
  output logic [CNT_W-1:0]  drop_ovf_cnt
);
  localparam int               PKT_W     = 1568;
  localparam logic [4:0]       LAST_WORD = 5'd24;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [PKT_W-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [1:0]       level_q, level_d;
  logic [4:0]       k_q, k_d;
  logic             out_valid_q, out_sop_q, out_eop_q;
  logic [63:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] crc_cnt_q, ovf_cnt_q;
  logic             wr_en_s, ovf_s, crc_fail_s, hs_s, last_hs_s;
  logic [PKT_W-1:0] src_s;

  // Words 0..23 are MSB-first slices; word 24 carries the final 32 bits, zero padded.
  function automatic logic [63:0] word_sel(input logic [PKT_W-1:0] pkt, input logic [4:0] k);
    logic [10:0] base;
    logic [63:0] w;
    base = 11'd1567 - {k, 6'd0};
    if (k < LAST_WORD) begin
      w = pkt[base -: 64];
    end else begin
      w = {pkt[31:0], 32'h0000_0000};
    end
    return w;
  endfunction

  // Ingress classification, egress progress and the next word to present.
  always_comb begin
    crc_fail_s = pkt_strobe && !crc10_check_result;
    wr_en_s    = pkt_strobe && crc10_check_result && (level_q != 2'd2);
    ovf_s      = pkt_strobe && crc10_check_result && (level_q == 2'd2);
    hs_s       = (state_q == SEND) && out_if.out_ready;
    last_hs_s  = hs_s && (k_q == LAST_WORD);

    level_d = level_q;
    if (wr_en_s && !last_hs_s) begin
      level_d = level_q + 2'd1;
    end else if (!wr_en_s && last_hs_s) begin
      level_d = level_q - 2'd1;
    end else begin
      level_d = level_q;
    end

    rd_ptr_d = rd_ptr_q ^ last_hs_s;

    if (last_hs_s) begin
      k_d = 5'd0;
    end else if (hs_s) begin
      k_d = k_q + 5'd1;
    end else begin
      k_d = k_q;
    end

    state_d = (level_d != 2'd0) ? SEND : IDLE;

    // A packet written this edge into the entry about to be read is taken straight from the input.
    if (wr_en_s && (rd_ptr_d == wr_ptr_q)) begin
      src_s = data_1568bit;
    end else begin
      src_s = mem_q[rd_ptr_d];
    end

    out_data_d = (state_d == SEND) ? word_sel(src_s, k_d) : 64'h0;
  end

  // Egress FSM, queue pointers, registered stream outputs and drop counters.
  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      level_q     <= 2'd0;
      k_q         <= 5'd0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= 64'h0;
      crc_cnt_q   <= {CNT_W{1'b0}};
      ovf_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      k_q         <= k_d;
      out_valid_q <= (state_d == SEND);
      out_sop_q   <= (state_d == SEND) && (k_d == 5'd0);
      out_eop_q   <= (state_d == SEND) && (k_d == LAST_WORD);
      out_data_q  <= out_data_d;
      if (wr_en_s) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (crc_fail_s && (crc_cnt_q != CNT_MAX)) begin
        crc_cnt_q <= crc_cnt_q + CNT_ONE;
      end
      if (ovf_s && (ovf_cnt_q != CNT_MAX)) begin
        ovf_cnt_q <= ovf_cnt_q + CNT_ONE;
      end
    end
  end

  // Packet storage; the level check keeps the entry under readout from being written.
  always_ff @(posedge clk_390p625M) begin
    if (!rst && wr_en_s) begin
      mem_q[wr_ptr_q] <= data_1568bit;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_sop   = out_sop_q;
  assign out_if.out_eop   = out_eop_q;
  assign out_if.out_data  = out_data_q;
  assign buf_level        = level_q;
  assign drop_crc_cnt     = crc_cnt_q;
  assign drop_ovf_cnt     = ovf_cnt_q;
endmodule
